// File: rtl/wb_commit_unit_if.sv
// Writeback commit bus: ALU and load requests in, registered register-file
// write port and commit indicator out.
//   master : request producers / register-file side (drives valids, payloads)
//   slave  : wb_commit_unit (drives readies, rf_we/rf_wr/rf_wd, busy)
interface wb_commit_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RADDR = 5
);
  logic             alu_valid;
  logic             alu_ready;
  logic [RADDR-1:0] alu_rd;
  logic [XLEN-1:0]  alu_data;

  logic             ld_valid;
  logic             ld_ready;
  logic [RADDR-1:0] ld_rd;
  logic [XLEN-1:0]  ld_data;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_addr_lo;

  logic             rf_we;
  logic [RADDR-1:0] rf_wr;
  logic [XLEN-1:0]  rf_wd;
  logic             busy;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    input  alu_ready, ld_ready, rf_we, rf_wr, rf_wd, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    output alu_ready, ld_ready, rf_we, rf_wr, rf_wd, busy
  );
endinterface

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback commit stage. Arbitrates between the ALU result
// path and the load path (alternating priority on conflict), formats load
// data (LB/LH/LW/LBU/LHU) and drives the register file write port through a
// one-cycle registered write. Writes to x0 are accepted but never enabled.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : wb_commit_unit_if.slave (alu_*, ld_* requests; rf_we/rf_wr/
//                rf_wd registered write; busy = a commit happens this cycle)
//   rr1/rr2, rd1_rf/rd2_rf, rd1_fwd/rd2_fwd : read-port bypass, present only
//                when WB_BYPASS_EN is defined
// Configuration macro: WB_BYPASS_EN
module wb_commit_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  wb_commit_unit_if.slave  bus
`ifdef WB_BYPASS_EN
  ,
  input  logic [RADDR-1:0] rr1,
  input  logic [RADDR-1:0] rr2,
  input  logic [XLEN-1:0]  rd1_rf,
  input  logic [XLEN-1:0]  rd2_rf,
  output logic [XLEN-1:0]  rd1_fwd,
  output logic [XLEN-1:0]  rd2_fwd
`endif
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  logic             prio;      // 0 = load wins a conflict, 1 = ALU wins
  logic             rf_we_q;
  logic [RADDR-1:0] rf_wr_q;
  logic [XLEN-1:0]  rf_wd_q;
  logic             busy_q;

  logic             ld_fire;
  logic             alu_fire;
  logic             both_valid;
  logic [BYTE_W-1:0] ld_byte;
  logic [HALF_W-1:0] ld_half;
  logic [XLEN-1:0]   ld_fmt;

  // Readies depend only on the other source's valid and prio, so they are
  // mutually exclusive whenever both sources request.
  assign bus.ld_ready  = !rst && !(bus.alu_valid && prio);
  assign bus.alu_ready = !rst && !(bus.ld_valid && !prio);

  assign ld_fire    = bus.ld_valid  && bus.ld_ready;
  assign alu_fire   = bus.alu_valid && bus.alu_ready;
  assign both_valid = bus.ld_valid  && bus.alu_valid;

  assign bus.rf_we = rf_we_q;
  assign bus.rf_wr = rf_wr_q;
  assign bus.rf_wd = rf_wd_q;
  assign bus.busy  = busy_q;

  // Load data formatting: byte lane from addr[1:0], half lane from addr[1].
  always_comb begin
    ld_byte = bus.ld_data[BYTE_W-1:0];
    case (bus.ld_addr_lo)
      2'd1:    ld_byte = bus.ld_data[2*BYTE_W-1:BYTE_W];
      2'd2:    ld_byte = bus.ld_data[3*BYTE_W-1:2*BYTE_W];
      2'd3:    ld_byte = bus.ld_data[4*BYTE_W-1:3*BYTE_W];
      default: ld_byte = bus.ld_data[BYTE_W-1:0];
    endcase
    ld_half = bus.ld_addr_lo[1] ? bus.ld_data[2*HALF_W-1:HALF_W]
                                : bus.ld_data[HALF_W-1:0];
    case (bus.ld_funct3)
      3'b000:  ld_fmt = {{(XLEN-BYTE_W){ld_byte[BYTE_W-1]}}, ld_byte};
      3'b100:  ld_fmt = {{(XLEN-BYTE_W){1'b0}}, ld_byte};
      3'b001:  ld_fmt = {{(XLEN-HALF_W){ld_half[HALF_W-1]}}, ld_half};
      3'b101:  ld_fmt = {{(XLEN-HALF_W){1'b0}}, ld_half};
      default: ld_fmt = bus.ld_data;
    endcase
  end

  // Commit register and arbitration priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio    <= 1'b0;
      rf_we_q <= 1'b0;
      rf_wr_q <= '0;
      rf_wd_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      busy_q  <= ld_fire || alu_fire;
      if (both_valid) begin
        prio <= !prio;
      end
      if (ld_fire) begin
        rf_we_q <= (bus.ld_rd != RADDR'(0));
        rf_wr_q <= bus.ld_rd;
        rf_wd_q <= ld_fmt;
      end else if (alu_fire) begin
        rf_we_q <= (bus.alu_rd != RADDR'(0));
        rf_wr_q <= bus.alu_rd;
        rf_wd_q <= bus.alu_data;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the committing value to readers of the same register; rf_we is
  // never set for x0, so x0 is never forwarded.
  assign rd1_fwd = (rf_we_q && (rf_wr_q == rr1)) ? rf_wd_q : rd1_rf;
  assign rd2_fwd = (rf_we_q && (rf_wr_q == rr2)) ? rf_wd_q : rd2_rf;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed testbench for wb_commit_unit: reset, load formatting, back-to-back
// commits, conflict arbitration, x0 drop, async reset mid-stream and (with
// WB_BYPASS_EN) read-port forwarding.
module tb_wb_commit_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_commit_unit_if #(.XLEN(32), .RADDR(5)) bus ();

`ifdef WB_BYPASS_EN
  logic [4:0]  rr1, rr2;
  logic [31:0] rd1_rf, rd2_rf, rd1_fwd, rd2_fwd;
`endif

  wb_commit_unit #(.XLEN(32), .RADDR(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WB_BYPASS_EN
    ,
    .rr1     (rr1),
    .rr2     (rr2),
    .rd1_rf  (rd1_rf),
    .rd2_rf  (rd2_rf),
    .rd1_fwd (rd1_fwd),
    .rd2_fwd (rd2_fwd)
`endif
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    step();
    step();
    checks++; if (bus.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b expected 0", bus.alu_ready); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b expected 0", bus.ld_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b expected 0", bus.rf_we); end
    checks++; if (bus.rf_wr !== 5'd0 || bus.rf_wd !== 32'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_regs: got wr=%0d wd=%h busy=%b expected 0/0/0", bus.rf_wr, bus.rf_wd, bus.busy); end
    rst = 1'b0;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL deassert_alu_ready: got %b expected 1", bus.alu_ready); end
    step();
    bus.alu_valid = 1'b0;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd5 || bus.rf_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL first_commit: got we=%b wr=%0d wd=%h expected 1/5/deadbeef", bus.rf_we, bus.rf_wr, bus.rf_wd); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL first_commit_busy: got %b expected 1", bus.busy); end
    step();
    checks++; if (bus.rf_we !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL first_commit_single: got we=%b busy=%b expected 0/0", bus.rf_we, bus.busy); end
    checks++; if (bus.rf_wr !== 5'd5 || bus.rf_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_hold: got wr=%0d wd=%h expected 5/deadbeef", bus.rf_wr, bus.rf_wd); end
  endtask

  // Back-to-back loads of 0x80FF7F01: continuous rf_we, one format per cycle.
  task automatic test_load_format();
    logic [2:0]  f3  [9] = '{3'b000, 3'b100, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011, 3'b001, 3'b000};
    logic [1:0]  lo  [9] = '{2'd3,   2'd1,   2'd2,   2'd2,   2'd0,   2'd3,   2'd1,   2'd3,   2'd0};
    logic [31:0] exp [9] = '{32'hFFFFFF80, 32'h0000007F, 32'h000000FF, 32'hFFFF80FF,
                             32'h00007F01, 32'h80FF7F01, 32'h80FF7F01, 32'hFFFF80FF,
                             32'h00000001};
    bus.ld_data = 32'h80FF7F01;
    for (int i = 0; i < 9; i++) begin
      bus.ld_valid   = 1'b1;
      bus.ld_funct3  = f3[i];
      bus.ld_addr_lo = lo[i];
      bus.ld_rd      = 5'(i + 1);
      #1;
      checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready[%0d]: got %b expected 1", i, bus.ld_ready); end
      step();
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'(i + 1) || bus.rf_wd !== exp[i]) begin errors++; $display("FAIL ld_fmt[%0d]: got we=%b wr=%0d wd=%h expected 1/%0d/%h", i, bus.rf_we, bus.rf_wr, bus.rf_wd, i + 1, exp[i]); end
    end
    bus.ld_valid = 1'b0;
    step();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL ld_stream_end: got %b expected 0", bus.rf_we); end
  endtask

  // Both sources valid: load first (prio 0), then ALU, then load again.
  task automatic test_conflict();
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd1;
    bus.ld_funct3  = 3'b010;
    bus.ld_addr_lo = 2'd0;
    bus.ld_data    = 32'h11111111;
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd2;
    bus.alu_data   = 32'h22222222;
    #1;
    checks++; if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL conflict_rdy0: got ld=%b alu=%b expected 1/0", bus.ld_ready, bus.alu_ready); end
    step();
    bus.ld_data = 32'h33333333;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd1 || bus.rf_wd !== 32'h11111111) begin errors++; $display("FAIL conflict_c1: got we=%b wr=%0d wd=%h expected 1/1/11111111", bus.rf_we, bus.rf_wr, bus.rf_wd); end
    checks++; if (bus.ld_ready !== 1'b0 || bus.alu_ready !== 1'b1) begin errors++; $display("FAIL conflict_rdy1: got ld=%b alu=%b expected 0/1", bus.ld_ready, bus.alu_ready); end
    step();
    bus.alu_data = 32'h44444444;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd2 || bus.rf_wd !== 32'h22222222) begin errors++; $display("FAIL conflict_c2: got we=%b wr=%0d wd=%h expected 1/2/22222222", bus.rf_we, bus.rf_wr, bus.rf_wd); end
    checks++; if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL conflict_rdy2: got ld=%b alu=%b expected 1/0", bus.ld_ready, bus.alu_ready); end
    step();
    bus.ld_valid = 1'b0;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd1 || bus.rf_wd !== 32'h33333333) begin errors++; $display("FAIL conflict_c3: got we=%b wr=%0d wd=%h expected 1/1/33333333", bus.rf_we, bus.rf_wr, bus.rf_wd); end
    step();
    bus.alu_valid = 1'b0;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd2 || bus.rf_wd !== 32'h44444444) begin errors++; $display("FAIL conflict_c4: got we=%b wr=%0d wd=%h expected 1/2/44444444", bus.rf_we, bus.rf_wr, bus.rf_wd); end
    step();
  endtask

  task automatic test_x0_drop();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'h00001234;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b expected 1", bus.alu_ready); end
    step();
    bus.alu_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL x0_drop: got busy=%b we=%b expected 1/0", bus.busy, bus.rf_we); end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL x0_after: got busy=%b we=%b expected 0/0", bus.busy, bus.rf_we); end
  endtask

  // Prio is 1 after the conflict sequence; reset must return it to load.
  task automatic test_async_reset();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd9;
    bus.alu_data  = 32'h00000099;
    step();
    bus.alu_valid = 1'b0;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd9) begin errors++; $display("FAIL pre_reset_commit: got we=%b wr=%0d expected 1/9", bus.rf_we, bus.rf_wr); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.rf_we !== 1'b0 || bus.rf_wr !== 5'd0 || bus.rf_wd !== 32'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL async_clear: got we=%b wr=%0d wd=%h busy=%b expected 0/0/0/0", bus.rf_we, bus.rf_wr, bus.rf_wd, bus.busy); end
    step();
    rst = 1'b0;
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd3;
    bus.ld_funct3  = 3'b010;
    bus.ld_data    = 32'hCAFEF00D;
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd4;
    #1;
    checks++; if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin errors++; $display("FAIL prio_after_reset: got ld=%b alu=%b expected 1/0", bus.ld_ready, bus.alu_ready); end
    step();
    bus.ld_valid = 1'b0;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wr !== 5'd3 || bus.rf_wd !== 32'hCAFEF00D) begin errors++; $display("FAIL post_reset_ld: got we=%b wr=%0d wd=%h expected 1/3/cafef00d", bus.rf_we, bus.rf_wr, bus.rf_wd); end
    step();
    bus.alu_valid = 1'b0;
    step();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    rr1 = 5'd7;
    rr2 = 5'd8;
    rd1_rf = 32'h00001111;
    rd2_rf = 32'h00002222;
    #1;
    checks++; if (rd1_fwd !== 32'h00001111) begin errors++; $display("FAIL byp_idle: got %h expected 00001111", rd1_fwd); end
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    bus.alu_data  = 32'hA5A5A5A5;
    step();
    bus.alu_rd   = 5'd0;
    bus.alu_data = 32'h5A5A5A5A;
    checks++; if (rd1_fwd !== 32'hA5A5A5A5 || rd2_fwd !== 32'h00002222) begin errors++; $display("FAIL byp_fwd: got rd1=%h rd2=%h expected a5a5a5a5/00002222", rd1_fwd, rd2_fwd); end
    rr1 = 5'd0;
    step();
    bus.alu_valid = 1'b0;
    checks++; if (rd1_fwd !== 32'h00001111) begin errors++; $display("FAIL byp_x0: got %h expected 00001111", rd1_fwd); end
    step();
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = '0;
    bus.alu_data   = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_rd      = '0;
    bus.ld_data    = '0;
    bus.ld_funct3  = '0;
    bus.ld_addr_lo = '0;
`ifdef WB_BYPASS_EN
    rr1 = '0;
    rr2 = '0;
    rd1_rf = '0;
    rd2_rf = '0;
`endif
    test_reset();
    test_load_format();
    test_conflict();
    test_x0_drop();
    test_async_reset();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
